// File: rtl/rr_priority_arb_v_pkg.sv
// Shared definitions for the request arbiters: mode encodings, FSM states and
// the pointer wrap helper.
package rr_priority_arb_v_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // Wraps at n rather than at a power of two, so non-power-of-2 widths rotate correctly.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_priority_arb_v_priority_enc.sv
// LSB-first combinational priority encoder: the lowest set bit of i_code wins.
module priority_enc_n_v #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     i_code,
  output logic [IDX_W-1:0] o_code,
  output logic             o_valid
);

  always_comb begin
    o_code  = '0;
    o_valid = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (i_code[k]) begin
        o_code  = IDX_W'(k);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_priority_arb_v.sv
// N-way request arbiter with a registered one-hot grant held until acknowledged;
// fixed-priority or round-robin selection chosen by MODE.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_IDLE | no grant held; any request is granted at the next edge
//   ST_BUSY | grant held until i_ack; on ack re-arbitrate among the others
module rr_priority_arb_v
  import rr_priority_arb_v_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int MODE  = MODE_RR,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_REQ-1:0] i_req,
  input  logic             i_ack,
  output logic [N_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0] o_gnt_idx,
  output logic             o_valid
);

  arb_state_e       state, state_n;
  logic [IDX_W-1:0] ptr, ptr_n, ptr_adv, arb_ptr;
  logic [IDX_W-1:0] idx_q, idx_n, win_idx;
  logic [N_REQ-1:0] gnt_q, gnt_n, arb_req, win_onehot;
  logic             win_valid;

  // On release the pointer used for re-arbitration is already the advanced one.
  assign ptr_adv = (MODE == MODE_RR) ? IDX_W'(wrap_inc(int'(idx_q), N_REQ)) : '0;
  assign arb_ptr = (state == ST_BUSY && i_ack) ? ptr_adv : ptr;
  assign arb_req = (state == ST_BUSY) ? (i_req & ~gnt_q) : i_req;

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic [N_REQ-1:0] mask_req;
      logic [IDX_W-1:0] m_idx, u_idx;
      logic             m_valid, u_valid;

      always_comb begin
        mask_req = '0;
        for (int k = 0; k < N_REQ; k++) begin
          mask_req[k] = arb_req[k] && (k >= int'(arb_ptr));
        end
      end

      priority_enc_n_v #(.N(N_REQ), .IDX_W(IDX_W)) u_enc_masked (
        .i_code  (mask_req),
        .o_code  (m_idx),
        .o_valid (m_valid)
      );

      priority_enc_n_v #(.N(N_REQ), .IDX_W(IDX_W)) u_enc_full (
        .i_code  (arb_req),
        .o_code  (u_idx),
        .o_valid (u_valid)
      );

      assign win_idx   = m_valid ? m_idx : u_idx;
      assign win_valid = u_valid;
    end else begin : g_fixed
      priority_enc_n_v #(.N(N_REQ), .IDX_W(IDX_W)) u_enc_full (
        .i_code  (arb_req),
        .o_code  (win_idx),
        .o_valid (win_valid)
      );
    end
  endgenerate

  assign win_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_IDLE;
      ptr   <= '0;
      gnt_q <= '0;
      idx_q <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      gnt_q <= gnt_n;
      idx_q <= idx_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    gnt_n   = gnt_q;
    idx_n   = idx_q;
    case (state)
      ST_IDLE: begin
        if (win_valid) begin
          state_n = ST_BUSY;
          gnt_n   = win_onehot;
          idx_n   = win_idx;
        end else begin
          gnt_n = '0;
          idx_n = '0;
        end
      end
      ST_BUSY: begin
        if (i_ack) begin
          ptr_n = ptr_adv;
          if (win_valid) begin
            gnt_n = win_onehot;
            idx_n = win_idx;
          end else begin
            state_n = ST_IDLE;
            gnt_n   = '0;
            idx_n   = '0;
          end
        end
      end
      default: begin
        state_n = ST_IDLE;
        gnt_n   = '0;
        idx_n   = '0;
      end
    endcase
  end

  assign o_gnt     = gnt_q;
  assign o_gnt_idx = idx_q;
  assign o_valid   = (state == ST_BUSY);

endmodule
